// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg: shared types and constants for the raster pixel path.
//   PIX_W_DEF / ROWS_DEF / COLS_DEF : default pixel width and frame size
//   tx_state_e                      : transmitter FSM states
//   pix_beat_t                      : one pixel plus its frame/line markers
//   clog2                           : ceil(log2(v)), never less than 1
package pixel_stream_pkg;

   localparam int PIX_W_DEF = 8;
   localparam int ROWS_DEF  = 168;
   localparam int COLS_DEF  = 220;

   typedef logic [PIX_W_DEF-1:0] pix_t;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} tx_state_e;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
      pix_t data;
   } pix_beat_t;

   // Counter width helper; a 1-entry range still needs a 1-bit counter.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/frame_pixel_tx_if.sv
// frame_pixel_tx_if: pixel stream and frame memory read port of the transmitter.
//   m_valid/m_ready/m_data/m_sof/m_eol/m_eof : output pixel stream
//   mem_rd_en/mem_addr/mem_rd_data           : synchronous-read memory port
//                                              (data valid 1 cycle after rd_en)
//   modport master : transmitter side;  modport slave : memory + sink side
interface frame_pixel_tx_if #(
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 16
);
   logic              m_valid;
   logic              m_ready;
   logic [PIX_W-1:0]  m_data;
   logic              m_sof;
   logic              m_eol;
   logic              m_eof;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [PIX_W-1:0]  mem_rd_data;

   modport master (
      output m_valid, m_data, m_sof, m_eol, m_eof, mem_rd_en, mem_addr,
      input  m_ready, mem_rd_data
   );

   modport slave (
      input  m_valid, m_data, m_sof, m_eol, m_eof, mem_rd_en, mem_addr,
      output m_ready, mem_rd_data
   );
endinterface

// File: rtl/pixel_skid_fifo.sv
// pixel_skid_fifo: 2-entry buffer of pix_beat_t between memory read return and
// the output stream.
//   clk, rst_n           : clock, async active-low reset (buffer emptied)
//   in_valid, in_beat    : write side; no ready, the producer only issues
//                          reads when a slot is guaranteed free
//   out_valid, out_ready : read side handshake; out_beat is the head entry
//   count                : current occupancy 0..2
// The head is a register, so out_beat holds still while out_ready is low.
module pixel_skid_fifo
   import pixel_stream_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      in_valid,
   input  pix_beat_t in_beat,
   output logic      out_valid,
   input  logic      out_ready,
   output pix_beat_t out_beat,
   output logic [1:0] count
);

   pix_beat_t e0, e1;
   logic      pop;

   assign out_valid = (count != 2'd0);
   assign out_beat  = e0;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0    <= '0;
         e1    <= '0;
         count <= 2'd0;
      end else begin
         case ({in_valid, pop})
            2'b10: begin
               if (count == 2'd0) e0 <= in_beat;
               else               e1 <= in_beat;
               count <= count + 2'd1;
            end
            2'b01: begin
               e0    <= e1;
               count <= count - 2'd1;
            end
            2'b11: begin
               // Simultaneous push/pop: occupancy unchanged, queue shifts.
               if (count == 2'd1) e0 <= in_beat;
               else begin
                  e0 <= e1;
                  e1 <= in_beat;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/frame_pixel_tx.sv
// frame_pixel_tx: reads a stored grayscale frame in row-major order
// (address = row*COLS + col) and streams it as valid/ready pixels with
// sof/eol/eof markers.
//   clk, rst_n  : clock, async active-low reset (abandons any frame in flight)
//   start       : one-cycle frame request, ignored while busy
//   busy        : frame in progress
//   done        : one-cycle pulse on the edge the eof pixel is accepted
//   bus         : frame_pixel_tx_if.master (stream out, memory read port)
// Build option FRAME_TX_PAD_EN: frame grows to (ROWS+2*PAD)x(COLS+2*PAD) with
// zero borders that take a buffer slot but no memory read.
module frame_pixel_tx
   import pixel_stream_pkg::*;
#(
   parameter int ROWS   = ROWS_DEF,
   parameter int COLS   = COLS_DEF,
   parameter int PIX_W  = PIX_W_DEF,
   parameter int ADDR_W = 16,
   parameter int PAD    = 2
)(
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic busy,
   output logic done,
   frame_pixel_tx_if.master bus
);

`ifdef FRAME_TX_PAD_EN
   localparam int PAD_T = PAD;
`else
   // Border disabled in this build.
   localparam int PAD_T = 0 * PAD;
`endif
   localparam int ROWS_T = ROWS + 2 * PAD_T;
   localparam int COLS_T = COLS + 2 * PAD_T;
   localparam int RW     = clog2(ROWS_T);
   localparam int CW     = clog2(COLS_T);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS * COLS - 1);

   tx_state_e         state, state_nx;
   logic [RW-1:0]     row;
   logic [CW-1:0]     col;
   logic [ADDR_W-1:0] addr;

   // One slot in flight between issue and memory return.
   logic              pend, pend_zero;
   logic [2:0]        pend_mk;

   logic              issue, border, last_slot, row_end, first_slot, pop;
   logic [1:0]        f_cnt;
   logic              f_valid;
   pix_beat_t         f_in, f_out;

   assign row_end    = (col == CW'(COLS_T - 1));
   assign last_slot  = row_end && (row == RW'(ROWS_T - 1));
   assign first_slot = (row == '0) && (col == '0);

`ifdef FRAME_TX_PAD_EN
   assign border = (int'(row) < PAD_T) || (int'(row) >= ROWS + PAD_T) ||
                   (int'(col) < PAD_T) || (int'(col) >= COLS + PAD_T);
`else
   assign border = 1'b0;
`endif

   assign pop = f_valid & bus.m_ready;

   // Occupancy after this cycle (buffered + in flight - leaving) must leave a
   // free slot for the slot issued now.
   assign issue = (state == RUN) &&
                  (({1'b0, f_cnt} + {2'b00, pend} - {2'b00, pop}) < 3'd2);

   assign bus.mem_rd_en = issue & ~border;
   assign bus.mem_addr  = addr;
   assign busy          = (state != IDLE);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start)                state_nx = RUN;
         RUN:     if (issue && last_slot)   state_nx = DRAIN;
         DRAIN:   if (pop && f_out.eof)     state_nx = IDLE;
         default:                           state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         row       <= '0;
         col       <= '0;
         addr      <= '0;
         pend      <= 1'b0;
         pend_zero <= 1'b0;
         pend_mk   <= '0;
         done      <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= (state == DRAIN) && pop && f_out.eof;
         pend  <= issue;
         if (issue) begin
            pend_zero <= border;
            pend_mk   <= {first_slot, row_end, last_slot};
         end
         if (state == IDLE && start) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
         end else if (issue) begin
            if (row_end) begin
               col <= '0;
               if (!last_slot) row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
            if (!border && addr != LAST_ADDR) addr <= addr + 1'b1;
         end
      end
   end

   always_comb begin
      f_in      = '0;
      f_in.sof  = pend_mk[2];
      f_in.eol  = pend_mk[1];
      f_in.eof  = pend_mk[0];
      f_in.data = pend_zero ? '0 : pix_t'(bus.mem_rd_data);
   end

   pixel_skid_fifo u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (pend),
      .in_beat   (f_in),
      .out_valid (f_valid),
      .out_ready (bus.m_ready),
      .out_beat  (f_out),
      .count     (f_cnt)
   );

   assign bus.m_valid = f_valid;
   assign bus.m_data  = PIX_W'(f_out.data);
   assign bus.m_sof   = f_out.sof;
   assign bus.m_eol   = f_out.eol;
   assign bus.m_eof   = f_out.eof;

endmodule

// File: tb/tb_frame_pixel_tx.sv
module tb_frame_pixel_tx;

`ifdef FRAME_TX_PAD_EN
   localparam int ROWS = 2;
   localparam int COLS = 2;
   localparam int NPIX = 16;
`else
   localparam int ROWS = 3;
   localparam int COLS = 4;
   localparam int NPIX = 12;
`endif
   localparam int PIX_W  = 8;
   localparam int ADDR_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, done;

   frame_pixel_tx_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

   frame_pixel_tx #(
      .ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .PAD(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .bus(bus)
   );

   always #5 clk = ~clk;

   // Synchronous-read frame memory.
   logic [7:0] mem [0:255];
   logic [7:0] rd_q;
   always @(posedge clk) if (bus.mem_rd_en) rd_q <= mem[bus.mem_addr];
   assign bus.mem_rd_data = rd_q;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   int hs_cnt, first_hs, last_hs, eof_cyc, rd_cnt, done_cyc;
   logic [10:0] exp_q[$];
   logic [7:0]  addr_log[$];
   logic [10:0] held;
   logic        hold_vld = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Scoreboard monitor: compares every accepted pixel, and checks that a
   // stalled pixel holds still until it is taken.
   always @(negedge clk) begin
      logic [10:0] cur, e;
      if (rst_n) begin
         cur = {bus.m_sof, bus.m_eol, bus.m_eof, bus.m_data};
         if (bus.mem_rd_en) begin
            rd_cnt++;
            addr_log.push_back(bus.mem_addr);
         end
         if (hold_vld) chk("stall_hold", {bus.m_valid, cur}, {1'b1, held});
         if (bus.m_valid && bus.m_ready) begin
            hs_cnt++;
            if (hs_cnt == 1) first_hs = cyc;
            last_hs = cyc;
            if (bus.m_eof) eof_cyc = cyc;
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL extra_pixel: got %0h expected none", cur);
            end else begin
               e = exp_q.pop_front();
               chk("pixel", {21'd0, cur}, {21'd0, e});
            end
            hold_vld = 1'b0;
         end else if (bus.m_valid) begin
            hold_vld = 1'b1;
            held     = cur;
         end else begin
            hold_vld = 1'b0;
         end
      end else begin
         hold_vld = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_stats();
      hs_cnt = 0; first_hs = 0; last_hs = 0; eof_cyc = -1; rd_cnt = 0; done_cyc = -1;
      addr_log.delete();
   endtask

   task automatic push_frame();
`ifdef FRAME_TX_PAD_EN
      logic [7:0] tbl [16] = '{8'h00, 8'h00, 8'h00, 8'h00,
                               8'h00, 8'hA1, 8'hB2, 8'h00,
                               8'h00, 8'hC3, 8'hD4, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 16; i++)
         exp_q.push_back({i == 0, (i % 4) == 3, i == 15, tbl[i]});
`else
      for (int i = 0; i < 12; i++)
         exp_q.push_back({i == 0, (i % 4) == 3, i == 11, 8'(i)});
`endif
   endtask

   // Runs until done; mode 0: ready high, 1: ready toggles 1,0,...
   // start_at >= 0 pulses start again at that cycle of the frame.
   task automatic run_frame(input string nm, input int mode, input int start_at);
      bit got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         bus.m_ready = (mode == 0) ? 1'b1 : ((i % 2) == 0);
         start = (i == start_at);
         tick();
         start = 1'b0;
         if (done) begin
            got = 1;
            done_cyc = cyc;
         end
      end
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_timeout: got no done expected done", nm);
      end
      bus.m_ready = 1'b1;
   endtask

   task automatic check_end(input string nm);
      chk({nm, "_count"}, hs_cnt, NPIX);
      chk({nm, "_done_edge"}, done_cyc, eof_cyc + 1);
      chk({nm, "_busy_at_done"}, busy, 0);
      chk({nm, "_queue_empty"}, exp_q.size(), 0);
      tick();
      chk({nm, "_done_one_cycle"}, done, 0);
   endtask

   initial begin
      bus.m_ready = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
`ifdef FRAME_TX_PAD_EN
      mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
`endif
      clr_stats();
      #12;
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", bus.mem_rd_en, 0);
      chk("rst_m_data", bus.m_data, 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

`ifdef FRAME_TX_PAD_EN
      // Padded 4x4 frame around a 2x2 image.
      push_frame();
      start = 1'b1; tick(); start = 1'b0;
      run_frame("pad", 0, -1);
      check_end("pad");
      chk("pad_reads", rd_cnt, 4);
      for (int i = 0; i < 4; i++)
         chk("pad_addr", (i < addr_log.size()) ? addr_log[i] : 8'hFF, i);
      chk("pad_contig", last_hs - first_hs, 15);
`else
      // 1: full-rate frame, latency and markers.
      push_frame();
      start = 1'b1; tick(); start = 1'b0;
      chk("lat_rd_en", bus.mem_rd_en, 1);
      chk("lat_addr0", bus.mem_addr, 0);
      chk("lat_busy", busy, 1);
      tick();
      chk("lat_valid_low", bus.m_valid, 0);
      tick();
      chk("lat_valid_high", bus.m_valid, 1);
      run_frame("full", 0, -1);
      check_end("full");
      chk("full_contig", last_hs - first_hs, 11);
      chk("full_reads", rd_cnt, 12);

      // 2: ready toggling.
      clr_stats(); push_frame();
      bus.m_ready = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      run_frame("toggle", 1, -1);
      check_end("toggle");

      // 3: held stall right after start.
      clr_stats(); push_frame();
      bus.m_ready = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      chk("stall_reads", rd_cnt, 2);
      chk("stall_hs", hs_cnt, 0);
      run_frame("stall", 0, -1);
      check_end("stall");
      chk("stall_contig", last_hs - first_hs, 11);
      chk("stall_total_reads", rd_cnt, 12);

      // 4: start while busy is ignored, then a clean second frame.
      clr_stats(); push_frame();
      start = 1'b1; tick(); start = 1'b0;
      run_frame("busy_start", 0, 5);
      check_end("busy_start");
      for (int i = 0; i < 20; i++) tick();
      chk("busy_start_no_extra", hs_cnt, 12);
      chk("busy_start_idle", busy, 0);
      clr_stats(); push_frame();
      start = 1'b1; tick(); start = 1'b0;
      run_frame("second", 0, -1);
      check_end("second");

      // 5: async reset at the handshake of pixel 5, then restart.
      clr_stats(); push_frame();
      start = 1'b1; tick(); start = 1'b0;
      begin
         bit seen = 0;
         for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.m_valid && bus.m_data == 8'h05) seen = 1;
            else tick();
         end
         chk("rst_mid_reach_px5", seen, 1);
      end
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", bus.m_valid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_rd_en", bus.mem_rd_en, 0);
      exp_q.delete();
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("rst_mid_stays_idle", busy, 0);
      clr_stats(); push_frame();
      start = 1'b1; tick(); start = 1'b0;
      run_frame("restart", 0, -1);
      check_end("restart");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/frame_pixel_tx.md
Name: frame_pixel_tx

Overview:
Synthesizable raster pixel transmitter: the read-out end of the frame/hex image path. It reads a stored grayscale frame from a synchronous-read frame memory in row-major order and streams it as a valid/ready pixel stream with frame and line markers. It feeds the streaming convolution and capture blocks. Its memory layout matches the loader: address = row*COLS + col.

Parameters:
ROWS, 168, frame height in pixels
COLS, 220, frame width in pixels
PIX_W, 8, pixel intensity width
ADDR_W, 16, frame memory address width; must satisfy 2**ADDR_W >= ROWS*COLS
PAD, 2, border width in pixels (KSIZE/2); used only when FRAME_TX_PAD_EN is defined

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to transmit one frame
busy  out  1  high while a frame is in progress
done  out  1  one-cycle pulse after the last pixel is accepted
mem_rd_en  out  1  frame memory read strobe
mem_addr  out  ADDR_W  frame memory read address
mem_rd_data  in  PIX_W  read data, valid exactly 1 cycle after mem_rd_en
m_valid  out  1  output pixel valid
m_ready  in  1  downstream ready
m_data  out  PIX_W  pixel value
m_sof  out  1  first pixel of frame
m_eol  out  1  last pixel of a row
m_eof  out  1  last pixel of frame

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low.
- Reset: all outputs are 0, the FSM goes to IDLE, counters are 0, and the buffer is empty. The reset takes effect immediately, including mid-frame. After reset the partial frame is abandoned and is not resumed.
- FSM states:
  - IDLE: waits for start.
  - RUN: issues reads until the last address has been issued.
  - DRAIN: waits for in-flight and buffered pixels to be accepted.
- FSM transitions:
  - IDLE to RUN on start. busy rises on the next edge.
  - RUN to DRAIN after the last read is issued.
  - DRAIN to IDLE on the handshake of the m_eof pixel. busy falls, and done pulses for exactly one cycle on that same edge.
- start is ignored while busy is high.
- Read issue: issue a read when (buffered entries + reads in flight - pixel leaving this cycle) < 2. The output buffer is 2 entries deep, so no read data is ever dropped.
- Throughput: with m_ready held high, one pixel per cycle.
- Latency: start is sampled at edge T. mem_rd_en/mem_addr=0 are asserted in cycle T+1, and m_valid first rises at T+2.
- Handshake: a transfer occurs when m_valid and m_ready are both high. Once m_valid is high, m_data, m_sof, m_eol and m_eof stay stable until the transfer. m_valid never depends combinationally on m_ready.
- Markers:
  - m_sof is high only with pixel (0,0).
  - m_eol is high when col == COLS-1.
  - m_eof is high with pixel (ROWS-1, COLS-1).
  - Markers travel with their pixel through the buffer.
- Counters: row and col wrap col COLS-1 to 0 with row+1. The address counter is separate and saturates after the last address. No read is issued beyond ROWS*COLS-1.
- Arithmetic: pixels pass through unmodified. No width conversion.

Optional Feature:
Macro FRAME_TX_PAD_EN.
- Defined: the transmitted frame is (ROWS+2*PAD) x (COLS+2*PAD).
  - Border pixels are emitted as 0 with no memory read.
  - Interior pixel (r,c) is read from address (r-PAD)*COLS + (c-PAD).
  - Markers refer to padded coordinates.
  - Zero pixels obey the same buffer-occupancy rule and ordering.
  - Default size is 172x224 = 38528 pixels.
- Undefined: exactly ROWS*COLS pixels. The PAD parameter has no effect.

Decomposition:
- Shared package pixel_stream_pkg holds:
  - PIX_W default
  - default ROWS/COLS
  - FSM state enum (IDLE, RUN, DRAIN)
  - marker-bundle typedef {sof, eol, eof, data}
  - clog2 helper
- One sub-module, pixel_skid_fifo: a 2-entry buffer carrying the marker bundle, with count output and valid/ready on its output side.

Test Plan:
1. ROWS=3, COLS=4, memory holds 0x00..0x0B, m_ready=1, start at T:
   - mem_rd_en at T+1 with addr 0.
   - 12 consecutive pixels 0x00..0x0B starting at T+2.
   - sof on pixel 0; eol on pixels 3, 7, 11; eof on pixel 11.
   - done pulse on the handshake edge of pixel 11.
2. Same frame, m_ready toggling 1,0,1,0:
   - All 12 pixels arrive in order with no loss or duplication.
   - Payload and markers are stable during stall cycles.
3. m_ready held 0 for 10 cycles after start:
   - Exactly 2 reads are issued, then none.
   - On release, pixels resume in order at 1 per cycle.
4. start pulsed while busy: ignored, and the pixel count stays 12. A second start after done retransmits identical data and markers.
5. rst_n driven low at the handshake of pixel 5:
   - m_valid, busy and mem_rd_en are 0 asynchronously.
   - After release plus start, the frame restarts at pixel 0x00 with sof.
6. FRAME_TX_PAD_EN, PAD=1, ROWS=2, COLS=2, memory holds A,B,C,D:
   - 16 pixels: 0,0,0,0, 0,A,B,0, 0,C,D,0, 0,0,0,0.
   - eol on every 4th pixel; eof on pixel 15.
   - Only 4 memory reads are issued.
